// File: rtl/ipdc_frame_collector_if.sv
// Pixel capture and display-stream signals of ipdc_frame_collector.
// The collector uses the slave view; the producer/sink environment uses master.
interface ipdc_frame_collector_if #(
  parameter int DATA_W = 24
);
  logic              i_pix_valid;
  logic [DATA_W-1:0] i_pix_data;
  logic              i_frame_abort;
  logic              o_px_valid;
  logic [DATA_W-1:0] o_px_data;
  logic              o_px_sof;
  logic              o_px_eof;
  logic              i_px_ready;

  modport master (
    output i_pix_valid, i_pix_data, i_frame_abort, i_px_ready,
    input  o_px_valid, o_px_data, o_px_sof, o_px_eof
  );

  modport slave (
    input  i_pix_valid, i_pix_data, i_frame_abort, i_px_ready,
    output o_px_valid, o_px_data, o_px_sof, o_px_eof
  );
endinterface

// File: rtl/ipdc_frame_collector.sv
// Two-bank ping-pong frame buffer behind ipdc: captures 16-pixel bursts, replays with sof/eof.
// Optional per-bank checksum on o_frame_sum when IPDC_FC_CHECKSUM_EN is defined.
module ipdc_frame_collector #(
  parameter int DATA_W    = 24,
  parameter int FRAME_PIX = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ipdc_frame_collector_if.slave  pix,
  output logic [1:0]             o_frames_pending,
  output logic                   o_overflow,
  output logic [DATA_W-1:0]      o_frame_sum
);

  localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIX - 1);

  logic [DATA_W-1:0] mem [2][FRAME_PIX];
  logic [1:0]        full, full_nxt;
  logic              wb, rb, drop;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;

  logic rd_xfer, rd_last, release_now;
  logic wr_start, wr_last, bank_busy, drop_now, pix_take, wr_en;

  always_comb begin
    rd_xfer     = full[rb] && pix.i_px_ready;
    rd_last     = (rd_cnt == LAST);
    release_now = rd_xfer && rd_last;
    wr_start    = (wr_cnt == '0);
    wr_last     = (wr_cnt == LAST);
    // A bank drained by this cycle's eof transfer may take a new frame start at once
    bank_busy   = full[wb] && !(release_now && (rb == wb));
    drop_now    = wr_start ? bank_busy : drop;
    pix_take    = pix.i_pix_valid && !pix.i_frame_abort;
    wr_en       = pix_take && !drop_now;
    full_nxt    = full;
    if (release_now)
      full_nxt[rb] = 1'b0;
    if (wr_en && wr_last)
      full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full       <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      drop       <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      o_overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (rd_xfer) begin
        if (rd_last) begin
          rd_cnt <= '0;
          rb     <= ~rb;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
      if (pix.i_frame_abort) begin
        wr_cnt <= '0;
        drop   <= 1'b0;
      end else if (pix.i_pix_valid) begin
        if (wr_start && bank_busy)
          o_overflow <= 1'b1;
        // Dropped frames still advance wr_cnt so the next burst stays aligned
        if (wr_last) begin
          wr_cnt <= '0;
          drop   <= 1'b0;
          if (!drop_now)
            wb <= ~wb;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
          drop   <= drop_now;
        end
      end
    end
  end

  // Bank storage is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wb][wr_cnt] <= pix.i_pix_data;
  end

  // Data and markers are gated by valid so every output reads 0 out of reset
  assign pix.o_px_valid = full[rb];
  assign pix.o_px_data  = full[rb] ? mem[rb][rd_cnt] : '0;
  assign pix.o_px_sof   = full[rb] && (rd_cnt == '0);
  assign pix.o_px_eof   = full[rb] && rd_last;
  assign o_frames_pending = {1'b0, full[0]} + {1'b0, full[1]};

`ifdef IPDC_FC_CHECKSUM_EN
  logic [DATA_W-1:0] sum [2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum[0] <= '0;
      sum[1] <= '0;
    end else if (pix.i_frame_abort) begin
      if (!full[wb])
        sum[wb] <= '0;
    end else if (wr_en) begin
      sum[wb] <= wr_start ? pix.i_pix_data : sum[wb] + pix.i_pix_data;
    end
  end

  assign o_frame_sum = full[rb] ? sum[rb] : '0;
`else
  assign o_frame_sum = '0;
`endif

endmodule

// File: tb/tb_ipdc_frame_collector.sv
// Directed bench for ipdc_frame_collector: capture, overflow drop, same-cycle
// bank reuse, abort, randomised backpressure and mid-readout reset.
module tb_ipdc_frame_collector;
    localparam int DATA_W    = 24;
    localparam int FRAME_PIX = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        frames_pending;
    logic              overflow;
    logic [DATA_W-1:0] frame_sum;
    int                checks = 0;
    int                errors = 0;

    ipdc_frame_collector_if #(.DATA_W(DATA_W)) bus ();

    ipdc_frame_collector #(
        .DATA_W   (DATA_W),
        .FRAME_PIX(FRAME_PIX)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .pix             (bus.slave),
        .o_frames_pending(frames_pending),
        .o_overflow      (overflow),
        .o_frame_sum     (frame_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef IPDC_FC_CHECKSUM_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic send_frame(input logic [23:0] base);
        for (int k = 0; k < FRAME_PIX; k++) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = base + 24'(k);
            tick();
        end
        bus.i_pix_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [23:0] base, input logic [31:0] s);
        for (int i = 0; i < FRAME_PIX; i++) begin
            chk({tag, "_valid"}, bus.o_px_valid, 1);
            chk({tag, "_data"}, bus.o_px_data, base + 24'(i));
            chk({tag, "_sof"}, bus.o_px_sof, (i == 0));
            chk({tag, "_eof"}, bus.o_px_eof, (i == FRAME_PIX - 1));
            chk({tag, "_sum"}, frame_sum, exp_sum(s));
            bus.i_px_ready = 1'b1;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx;
        int budget;
        bus.i_pix_valid   = 1'b0;
        bus.i_pix_data    = '0;
        bus.i_frame_abort = 1'b0;
        bus.i_px_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", bus.o_px_valid, 0);
        chk("rst_sof", bus.o_px_sof, 0);
        chk("rst_eof", bus.o_px_eof, 0);
        chk("rst_pending", frames_pending, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sum", frame_sum, 0);
        rst_n = 1'b1;

        // Single frame 1..16, ready high, latency of one edge after last write
        bus.i_px_ready = 1'b1;
        for (int k = 0; k < FRAME_PIX; k++) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = 24'(k + 1);
            tick();
            if (k == FRAME_PIX - 2) chk("lat_before", bus.o_px_valid, 0);
        end
        bus.i_pix_valid = 1'b0;
        chk("lat_pending", frames_pending, 1);
        drain("f1", 24'h000001, 32'h000088);
        chk("f1_done_valid", bus.o_px_valid, 0);
        chk("f1_done_pending", frames_pending, 0);

        // Overflow: A, B kept, C dropped
        bus.i_px_ready = 1'b0;
        send_frame(24'h0A0000);
        send_frame(24'h0B0000);
        chk("ov_pend2", frames_pending, 2);
        chk("ov_not_yet", overflow, 0);
        send_frame(24'h0C0000);
        chk("ov_pend_after_c", frames_pending, 2);
        chk("ov_flag", overflow, 1);
        drain("ovA", 24'h0A0000, 32'h00A00078);
        drain("ovB", 24'h0B0000, 32'h00B00078);
        chk("ov_done_pending", frames_pending, 0);
        chk("ov_sticky", overflow, 1);

        // Same-cycle release of A's bank and acceptance of C's first pixel
        do_reset();
        chk("rst2_overflow", overflow, 0);
        bus.i_px_ready = 1'b0;
        send_frame(24'h0A0000);
        send_frame(24'h0B0000);
        chk("sc_pend2", frames_pending, 2);
        bus.i_px_ready = 1'b1;
        for (int i = 0; i < FRAME_PIX - 1; i++) begin
            chk("sc_A_data", bus.o_px_data, 24'h0A0000 + 24'(i));
            tick();
        end
        chk("sc_A_eof", bus.o_px_eof, 1);
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = 24'h0C0000;
        tick();
        for (int i = 0; i < FRAME_PIX; i++) begin
            chk("sc_B_data", bus.o_px_data, 24'h0B0000 + 24'(i));
            chk("sc_B_sof", bus.o_px_sof, (i == 0));
            chk("sc_B_eof", bus.o_px_eof, (i == FRAME_PIX - 1));
            if (i < FRAME_PIX - 1) begin
                bus.i_pix_valid = 1'b1;
                bus.i_pix_data  = 24'h0C0000 + 24'(i + 1);
            end else begin
                bus.i_pix_valid = 1'b0;
            end
            tick();
        end
        chk("sc_overflow", overflow, 0);
        chk("sc_pend1", frames_pending, 1);
        drain("scC", 24'h0C0000, 32'h00C00078);
        chk("sc_done_pending", frames_pending, 0);

        // Abort after 7 pixels; a pixel alongside abort is discarded
        bus.i_px_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = 24'h770000 + 24'(k);
            tick();
        end
        bus.i_frame_abort = 1'b1;
        bus.i_pix_data    = 24'h123456;
        tick();
        bus.i_frame_abort = 1'b0;
        bus.i_pix_valid   = 1'b0;
        chk("ab_pend0", frames_pending, 0);
        send_frame(24'hAA0000);
        chk("ab_pend1", frames_pending, 1);
        drain("ab", 24'hAA0000, 32'h00A00078);
        chk("ab_done_pending", frames_pending, 0);
        chk("ab_done_valid", bus.o_px_valid, 0);

        // Random backpressure: expected pixel advances only on accepted transfers
        send_frame(24'h550000);
        idx = 0;
        budget = 0;
        while (idx < FRAME_PIX && budget < 300) begin
            bus.i_px_ready = 1'($urandom_range(0, 1));
            chk("rnd_valid", bus.o_px_valid, 1);
            chk("rnd_data", bus.o_px_data, 24'h550000 + 24'(idx));
            chk("rnd_sof", bus.o_px_sof, (idx == 0));
            chk("rnd_eof", bus.o_px_eof, (idx == FRAME_PIX - 1));
            tick();
            if (bus.i_px_ready) idx++;
            budget++;
        end
        chk("rnd_complete", idx, FRAME_PIX);
        chk("rnd_done_valid", bus.o_px_valid, 0);

        // Reset during readout with two frames pending and overflow set
        bus.i_px_ready = 1'b0;
        send_frame(24'h110000);
        send_frame(24'h220000);
        send_frame(24'h990000);
        chk("mr_pend2", frames_pending, 2);
        chk("mr_ovf", overflow, 1);
        bus.i_px_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_mid_data", bus.o_px_data, 24'h110003);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", bus.o_px_valid, 0);
        chk("mr_pending", frames_pending, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_sum", frame_sum, 0);
        rst_n = 1'b1;
        bus.i_px_ready = 1'b0;
        send_frame(24'h330000);
        chk("mr_new_pend", frames_pending, 1);
        drain("mrN", 24'h330000, 32'h00300078);
        chk("mr_new_done", frames_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
